// File: rtl/fifo_reader.sv
// fifo_reader: drains an 8-bit FIFO read port and packs PACK bytes per word.
// Ports: clk, rst (async active-low); FIFO side fifo_e/fifo_rreq/fifo_rd;
// flush closes a partial word; out_valid/out_ready/out_data/out_be/out_last
// carry the packed word; word_cnt counts accepted words (wraps).
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_e,
  output logic                   fifo_rreq,
  input  logic [DATA_W-1:0]      fifo_rd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PACK*DATA_W-1:0] out_data,
  output logic [PACK-1:0]        out_be,
  output logic                   out_last,
  output logic [15:0]            word_cnt
);

  localparam int FW = $clog2(PACK + 1);
  localparam logic [FW-1:0] FULL = FW'(PACK);

  logic [FW-1:0]               fill;
  logic                        inflight;
  logic                        flush_pend;
  logic [PACK-1:0][DATA_W-1:0] pack;

  logic [FW:0]                 occ;
  logic [PACK-1:0]             mask;
  logic [PACK*DATA_W-1:0]      masked;
  logic                        out_free;
  logic                        full_mv;
  logic                        flush_mv;
  logic                        move;

  always_comb begin
    occ      = {1'b0, fill} + {{FW{1'b0}}, inflight};
    out_free = !out_valid || out_ready;
    full_mv  = (fill == FULL);
    flush_mv = flush_pend && !inflight && (fill != '0);
    move     = out_free && (full_mv || flush_mv);
    // Reserve a lane for the byte still in flight so the pack
    // register can never overflow.
    fifo_rreq = rst && !fifo_e && !flush_pend
             && (occ < {1'b0, FULL});
    mask   = '0;
    masked = '0;
    for (int i = 0; i < PACK; i++) begin
      mask[i] = (FW'(i) < fill);
      masked[i*DATA_W +: DATA_W] = mask[i] ? pack[i] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill       <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      pack       <= '0;
    end else begin
      inflight <= fifo_rreq;
      // A move needs inflight=0 (fill==PACK implies it),
      // so the two branches never collide.
      if (move) begin
        fill <= '0;
      end else if (inflight) begin
        fill <= fill + FW'(1);
        for (int i = 0; i < PACK; i++) begin
          if (fill == FW'(i)) pack[i] <= fifo_rd;
        end
      end
      if (flush_pend) begin
        if (!inflight && (fill == '0 || move))
          flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (move) begin
        out_valid <= 1'b1;
        out_data  <= masked;
        out_be    <= mask;
        out_last  <= flush_mv;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed tests for fifo_reader with a small FIFO model.
// Each scenario task drives stimulus and checks its own results.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_e;
  logic        fifo_rreq;
  logic [7:0]  fifo_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_last;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] rd_ptr = '0;
  logic [7:0] wr_ptr = '0;
  int         acc_cnt = 0;
  int         viol = 0;

  logic [31:0] cap_data [64];
  logic [3:0]  cap_be   [64];
  logic        cap_last [64];
  int          cap_n = 0;

  fifo_reader #(.DATA_W(8), .PACK(4)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_e(fifo_e),
    .fifo_rreq(fifo_rreq),
    .fifo_rd(fifo_rd),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_be(out_be),
    .out_last(out_last),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_e = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rreq && !fifo_e) begin
      fifo_rd <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
      acc_cnt <= acc_cnt + 1;
    end
    if (fifo_rreq && fifo_e) viol <= viol + 1;
    if (rst && out_valid && out_ready) begin
      cap_data[cap_n[5:0]] <= out_data;
      cap_be[cap_n[5:0]]   <= out_be;
      cap_last[cap_n[5:0]] <= out_last;
      cap_n <= cap_n + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_cap(input int n, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cap_n >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (fifo_rreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_rreq got %b exp 0", fifo_rreq);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    if (word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 0000", word_cnt);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", out_data);
    end
  endtask

  task automatic test_full_words;
    int n0;
    int lat;
    bit ok;
    n0 = cap_n;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL first_latency got %0d exp 6", lat);
    end
    wait_cap(n0 + 2, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_timeout got %0d exp %0d", cap_n, n0 + 2);
    end
    checks++;
    if (cap_data[n0] !== 32'h04030201 || cap_be[n0] !== 4'hF
        || cap_last[n0] !== 1'b0) begin
      errors++;
      $display("FAIL full_w0 got %h/%h/%b exp 04030201/f/0",
               cap_data[n0], cap_be[n0], cap_last[n0]);
    end
    checks++;
    if (cap_data[n0+1] !== 32'h08070605) begin
      errors++;
      $display("FAIL full_w1 got %h exp 08070605", cap_data[n0+1]);
    end
    @(negedge clk);
    checks++;
    if (word_cnt !== 16'd2) begin
      errors++;
      $display("FAIL full_cnt got %0d exp 2", word_cnt);
    end
  endtask

  task automatic test_backpressure;
    int a0;
    int bad;
    bit seen;
    a0 = acc_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid_timeout got 0 exp 1");
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_data !== 32'h13121110 || out_be !== 4'hF
          || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
    end
    checks++;
    if (dut.fill !== 3'd4) begin
      errors++;
      $display("FAIL bp_fill got %0d exp 4", dut.fill);
    end
    checks++;
    if (acc_cnt - a0 !== 8) begin
      errors++;
      $display("FAIL bp_reads got %0d exp 8", acc_cnt - a0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h17161514) begin
      errors++;
      $display("FAIL bp_next got %b/%h exp 1/17161514",
               out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (word_cnt !== 16'd4) begin
      errors++;
      $display("FAIL bp_cnt got %0d exp 4", word_cnt);
    end
  endtask

  task automatic test_partial_flush;
    int n0;
    bit ok;
    n0 = cap_n;
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_cap(n0 + 1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pflush_timeout got %0d exp %0d", cap_n, n0 + 1);
    end
    checks++;
    if (cap_data[n0] !== 32'h00A2A1A0 || cap_be[n0] !== 4'b0111
        || cap_last[n0] !== 1'b1) begin
      errors++;
      $display("FAIL pflush_word got %h/%b/%b exp 00a2a1a0/0111/1",
               cap_data[n0], cap_be[n0], cap_last[n0]);
    end
    checks++;
    if (word_cnt !== 16'd5) begin
      errors++;
      $display("FAIL pflush_cnt got %0d exp 5", word_cnt);
    end
  endtask

  task automatic test_inflight_flush;
    int n0;
    bit ok;
    n0 = cap_n;
    push(8'h55);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_cap(n0 + 1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL iflush_timeout got %0d exp %0d", cap_n, n0 + 1);
    end
    checks++;
    if (cap_data[n0] !== 32'h00000055 || cap_be[n0] !== 4'b0001
        || cap_last[n0] !== 1'b1) begin
      errors++;
      $display("FAIL iflush_word got %h/%b/%b exp 00000055/0001/1",
               cap_data[n0], cap_be[n0], cap_last[n0]);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cap_n !== n0 + 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL eflush_word got %0d words exp %0d", cap_n, n0 + 1);
    end
    checks++;
    if (dut.flush_pend !== 1'b0) begin
      errors++;
      $display("FAIL eflush_pend got %b exp 0", dut.flush_pend);
    end
    checks++;
    if (word_cnt !== 16'd6) begin
      errors++;
      $display("FAIL eflush_cnt got %0d exp 6", word_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    bit ok;
    push(8'hB0);
    push(8'hB1);
    push(8'hB2);
    repeat (3) @(negedge clk);
    checks++;
    if (dut.fill !== 3'd2 || dut.inflight !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got fill %0d inflight %b exp 2/1",
               dut.fill, dut.inflight);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (fifo_rreq !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0
        || out_be !== 4'h0 || out_last !== 1'b0
        || word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rmid_outs got %b %b %h %h %b %h exp all zero",
               fifo_rreq, out_valid, out_data, out_be, out_last,
               word_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    n0 = cap_n;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    wait_cap(n0 + 1, 20, ok);
    checks++;
    if (!ok || cap_data[n0] !== 32'hC3C2C1C0
        || cap_be[n0] !== 4'hF) begin
      errors++;
      $display("FAIL rmid_word got %h/%h exp c3c2c1c0/f",
               cap_data[n0], cap_be[n0]);
    end
    checks++;
    if (word_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rmid_cnt got %0d exp 1", word_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    bit ok;
    n0 = cap_n;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    wait_cap(n0 + 4, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout got %0d exp %0d", cap_n, n0 + 4);
    end
    checks++;
    if (cap_data[n0] !== 32'h23222120
        || cap_data[n0+3] !== 32'h2F2E2D2C) begin
      errors++;
      $display("FAIL b2b_words got %h %h exp 23222120 2f2e2d2c",
               cap_data[n0], cap_data[n0+3]);
    end
    checks++;
    if (word_cnt !== 16'd5) begin
      errors++;
      $display("FAIL b2b_cnt got %0d exp 5", word_cnt);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL rreq_empty got %0d exp 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_full_words;
    test_backpressure;
    test_partial_flush;
    test_inflight_flush;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
